lcd_i2c_seq: RTL and testbench
==============================

Name: lcd_i2c_seq

Overview:
- Controller that sequences the byte-level I2C master to drive an HD44780 character LCD behind a PCF8574 I2C expander.
- Runs the HD44780 4-bit power-on init sequence. It then accepts command and data bytes from upstream logic, such as the parking-status display formatter.
- Each LCD byte is split into nibble transfers with EN strobes, and the required HD44780 execution delays are inserted between bytes.
- Sits between the application logic and i2c_master, and owns the master's start/data handshake.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; must be a multiple of 1_000_000.
- I2C_ADDR, 7'h27, PCF8574 slave address driven on i2c_addr.
- POWERUP_MS, 50, wait after reset before the first I2C transfer.
- BACKLIGHT, 1, value of expander bit P3 in every transferred byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  upstream has a byte to write
- req_rs  in  1  0 = command, 1 = character data
- req_byte  in  8  byte to write to the LCD
- req_ready  out  1  controller can accept a request this cycle
- init_done  out  1  init sequence completed
- err  out  1  sticky NACK error
- i2c_start  out  1  one-cycle pulse that starts one I2C byte write
- i2c_addr  out  7  constant I2C_ADDR
- i2c_data  out  8  expander byte; stable from i2c_start until i2c_done
- i2c_busy  in  1  master is mid-transaction
- i2c_done  in  1  one-cycle pulse at the end of a transaction
- i2c_nack  in  1  slave NACK; valid only while i2c_done = 1

Behaviour:
- Reset values: req_ready=0, init_done=0, err=0, i2c_start=0, i2c_data=8'h00. State is POWERUP with the timer cleared.
- Expander byte format is {D7..D4, BL, EN, RW=0, RS}.
- Each nibble costs two I2C writes: first with EN=1, then identical with EN=0.
- A full byte is sent as four writes: hi-EN, hi-noEN, lo-EN, lo-noEN.
- Timer: one shared down-counter of 1 µs ticks, with US_CYCLES = CLK_HZ/1_000_000 clocks per tick. It is 32 bits wide and holds values up to POWERUP_MS*1000 µs.
- State machine:
  - POWERUP: wait POWERUP_MS, then go to INIT_LOAD.
  - INIT_LOAD: fetch the ROM entry at init_idx (0..7), then go to SEND.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_rs and req_byte, then go to SEND.
  - SEND: when !i2c_busy, pulse i2c_start for exactly 1 cycle with the current phase's byte on i2c_data, then go to WAIT_DONE.
  - WAIT_DONE: on i2c_done with i2c_nack, go to ERROR. On i2c_done without i2c_nack, advance the phase. If more phases remain, go to SEND; otherwise go to DELAY.
  - DELAY: load the delay for this byte and count it down. Then go to INIT_LOAD if init is unfinished, or to IDLE otherwise.
  - ERROR: err=1, req_ready=0; stays there until reset.
- Init ROM entries, in order (nibble-only entries send 2 writes, full entries send 4):
  - 0x3 nibble, 5000 µs
  - 0x3 nibble, 200 µs
  - 0x3 nibble, 200 µs
  - 0x2 nibble, 200 µs
  - 0x28 full, 50 µs
  - 0x0C full, 50 µs
  - 0x01 full, 2000 µs
  - 0x06 full, 50 µs
  - All init entries use RS=0.
- init_done rises in the same cycle the state first becomes IDLE; it stays high until reset.
- Runtime byte delay is 2000 µs when rs=0 and byte is 0x01 or 0x02, and 50 µs for every other byte.
- Latency: a request accepted at cycle N puts i2c_start=1 at cycle N+1, provided i2c_busy=0.
- i2c_done outside WAIT_DONE is ignored.
- A simultaneous i2c_done and i2c_nack counts as an error.
- req_valid outside IDLE is not accepted; upstream must hold it until it sees req_ready.
- If rst_n is asserted mid-transfer, outputs return to reset values immediately and the POWERUP wait restarts. A transaction already in progress in the master is not completed by this block.

Decomposition:
- Package lcd_i2c_pkg holds:
  - the state enum
  - the expander bit positions (RS=0, RW=1, EN=2, BL=3, D4=4)
  - the init ROM as constant arrays: nibble_only flag, byte and delay_us, 8 entries
  - the delay constants (DLY_SHORT_US=50, DLY_CLEAR_US=2000)
- One natural sub-module, lcd_us_timer: a µs prescaler plus down-counter with load/busy. It is reused for POWERUP and DELAY.

Test Plan:
1. CLK_HZ=1_000_000, POWERUP_MS=1, master model acks after 10 cycles. Release reset, then expect:
   - no i2c_start for 1000 cycles
   - init emits i2c_data 0x3C,0x38 ×3, then 0x2C,0x28, then the 0x28/0x0C/0x01/0x06 byte quartets
   - init_done and req_ready rise only after the final 50 µs delay
2. After init, send req_rs=1, req_byte=0x48. Expect:
   - i2c_start on the next cycle
   - i2c_data sequence 0x4D,0x49,0x8D,0x89
   - req_ready low for 4 transfers plus 50 µs, then high again
3. Send req_rs=0, req_byte=0x01 → i2c_data 0x0C,0x08,0x1C,0x18, then a 2000 µs gap before req_ready returns.
4. Master asserts i2c_nack with i2c_done on the second write of a request → err=1 and req_ready=0 permanently; no further i2c_start.
5. Hold i2c_busy=1 for 20 cycles while in SEND → i2c_start is withheld until busy falls, then pulses exactly once with i2c_data unchanged.
6. Assert rst_n=0 during WAIT_DONE of a data byte → all outputs take reset values asynchronously; after release the full POWERUP and init sequence repeats.

Source files
------------

// File: rtl/lcd_i2c_pkg.sv
// lcd_i2c_pkg: shared types and constants for the HD44780-over-PCF8574 sequencer.
//   - lcd_state_e      : sequencer state encoding
//   - EXP_*            : PCF8574 bit positions of the LCD control/data lines
//   - INIT_*           : 8-entry power-on init ROM (nibble flag, byte, delay)
//   - exp_byte()       : builds one expander byte from nibble/EN/RS/BL
//   - run_dly_us()     : execution delay for a runtime LCD byte
package lcd_i2c_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_LOAD,
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_ERROR
  } lcd_state_e;

  localparam int EXP_RS = 0;
  localparam int EXP_RW = 1;
  localparam int EXP_EN = 2;
  localparam int EXP_BL = 3;
  localparam int EXP_D4 = 4;

  localparam int DLY_SHORT_US = 50;
  localparam int DLY_CLEAR_US = 2000;

  localparam int INIT_LEN = 8;

  // Bit i set: entry i is a lone nibble (held in the low 4 bits of INIT_BYTE).
  localparam logic [INIT_LEN-1:0] INIT_NIB_ONLY = 8'b0000_1111;

  localparam logic [7:0] INIT_BYTE [INIT_LEN] = '{
    8'h03, 8'h03, 8'h03, 8'h02, 8'h28, 8'h0C, 8'h01, 8'h06
  };

  localparam logic [31:0] INIT_DLY_US [INIT_LEN] = '{
    32'd5000, 32'd200, 32'd200, 32'd200, 32'd50, 32'd50, 32'd2000, 32'd50
  };

  function automatic logic [7:0] exp_byte(input logic [3:0] nib, input logic en,
                                          input logic rs, input logic bl);
    logic [7:0] b;
    b = 8'h00;
    b[EXP_D4 +: 4] = nib;
    b[EXP_BL]      = bl;
    b[EXP_EN]      = en;
    b[EXP_RW]      = 1'b0;
    b[EXP_RS]      = rs;
    return b;
  endfunction

  // Clear (0x01) and home (0x02) are the slow HD44780 commands.
  function automatic logic [31:0] run_dly_us(input logic rs, input logic [7:0] b);
    if (!rs && (b == 8'h01 || b == 8'h02)) return 32'(DLY_CLEAR_US);
    return 32'(DLY_SHORT_US);
  endfunction

endpackage

// File: rtl/lcd_us_timer.sv
// lcd_us_timer: microsecond prescaler plus 32-bit down-counter.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_us and restart the prescaler
//   i_load_us   : delay in microseconds
//   o_busy      : high while the loaded delay has not yet expired
module lcd_us_timer #(
  parameter int US_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_us,
  output logic        o_busy
);

  localparam int PW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(US_CYCLES - 1);

  logic [PW-1:0] r_pre;
  logic [31:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_pre <= PRE_MAX;
      r_cnt <= i_load_us;
    end else if (r_cnt != 32'd0) begin
      if (r_pre == '0) begin
        r_pre <= PRE_MAX;
        r_cnt <= r_cnt - 32'd1;
      end else begin
        r_pre <= r_pre - PW'(1);
      end
    end
  end

  assign o_busy = (r_cnt != 32'd0);

endmodule

// File: rtl/lcd_i2c_seq.sv
// lcd_i2c_seq: drives an HD44780 LCD through a PCF8574 expander by sequencing
// a byte-level I2C master. Runs the 4-bit init sequence after power-up, then
// accepts command/data bytes from upstream.
//   req_valid/req_rs/req_byte/req_ready : upstream byte request handshake
//   init_done : init sequence complete (sticky until reset)
//   err       : sticky NACK error
//   i2c_start/i2c_addr/i2c_data         : one-byte write request to the master
//   i2c_busy/i2c_done/i2c_nack          : master status
module lcd_i2c_seq
  import lcd_i2c_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter logic [6:0] I2C_ADDR   = 7'h27,
  parameter int         POWERUP_MS = 50,
  parameter int         BACKLIGHT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_byte,
  output logic       req_ready,
  output logic       init_done,
  output logic       err,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack
);

  localparam int         US_CYCLES  = CLK_HZ / 1_000_000;
  localparam logic [31:0] POWERUP_US = 32'(POWERUP_MS * 1000);

  lcd_state_e  r_state;
  logic        r_armed;      // timer loaded for the current POWERUP/DELAY visit
  logic [3:0]  r_init_idx;   // next ROM entry; 8 means init ROM exhausted
  logic        r_rs;
  logic [7:0]  r_byte;
  logic        r_nib_only;
  logic [1:0]  r_phase;      // [1]=low nibble, [0]=EN-low write
  logic [31:0] r_dly_us;
  logic        r_req_ready;
  logic        r_init_done;
  logic        r_err;
  logic        r_start;
  logic [7:0]  r_data;

  logic        w_bl;
  logic        w_tmr_load;
  logic [31:0] w_tmr_load_us;
  logic        w_tmr_busy;
  logic [3:0]  w_nib;
  logic [7:0]  w_send_byte;
  logic        w_last_phase;
  logic [2:0]  w_rom_idx;

  assign w_bl          = (BACKLIGHT != 0);
  assign w_tmr_load    = ((r_state == ST_POWERUP) || (r_state == ST_DELAY)) && !r_armed;
  assign w_tmr_load_us = (r_state == ST_POWERUP) ? POWERUP_US : r_dly_us;
  assign w_nib         = r_phase[1] ? r_byte[3:0] : r_byte[7:4];
  assign w_send_byte   = exp_byte(w_nib, ~r_phase[0], r_rs, w_bl);
  assign w_last_phase  = r_nib_only ? (r_phase == 2'd1) : (r_phase == 2'd3);
  assign w_rom_idx     = r_init_idx[2:0];

  lcd_us_timer #(.US_CYCLES(US_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_load_us (w_tmr_load_us),
    .o_busy    (w_tmr_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_POWERUP;
      r_armed     <= 1'b0;
      r_init_idx  <= 4'd0;
      r_rs        <= 1'b0;
      r_byte      <= 8'h00;
      r_nib_only  <= 1'b0;
      r_phase     <= 2'd0;
      r_dly_us    <= 32'd0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_POWERUP: begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (!w_tmr_busy) begin
            r_armed <= 1'b0;
            r_state <= ST_INIT_LOAD;
          end
        end
        ST_INIT_LOAD: begin
          // Lone nibbles go out on D7..D4, so park them in the high half.
          r_byte     <= INIT_NIB_ONLY[w_rom_idx] ? {INIT_BYTE[w_rom_idx][3:0], 4'h0}
                                                 : INIT_BYTE[w_rom_idx];
          r_nib_only <= INIT_NIB_ONLY[w_rom_idx];
          r_dly_us   <= INIT_DLY_US[w_rom_idx];
          r_rs       <= 1'b0;
          r_phase    <= 2'd0;
          r_init_idx <= r_init_idx + 4'd1;
          r_state    <= ST_SEND;
        end
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_rs        <= req_rs;
            r_byte      <= req_byte;
            r_nib_only  <= 1'b0;
            r_phase     <= 2'd0;
            r_dly_us    <= run_dly_us(req_rs, req_byte);
            // Issue the first write straight from the accept edge so the
            // start pulse lands one cycle after acceptance.
            if (!i2c_busy) begin
              r_start <= 1'b1;
              r_data  <= exp_byte(req_byte[7:4], 1'b1, req_rs, w_bl);
              r_state <= ST_WAIT_DONE;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (!i2c_busy) begin
            r_start <= 1'b1;
            r_data  <= w_send_byte;
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i2c_done) begin
            if (i2c_nack) begin
              r_err       <= 1'b1;
              r_req_ready <= 1'b0;
              r_state     <= ST_ERROR;
            end else if (w_last_phase) begin
              r_state <= ST_DELAY;
            end else begin
              r_phase <= r_phase + 2'd1;
              r_state <= ST_SEND;
            end
          end
        end
        ST_DELAY: begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (!w_tmr_busy) begin
            r_armed <= 1'b0;
            if (r_init_idx != 4'(INIT_LEN)) begin
              r_state <= ST_INIT_LOAD;
            end else begin
              r_state     <= ST_IDLE;
              r_req_ready <= 1'b1;
              r_init_done <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          r_err       <= 1'b1;
          r_req_ready <= 1'b0;
        end
        default: r_state <= ST_ERROR;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign init_done = r_init_done;
  assign err       = r_err;
  assign i2c_start = r_start;
  assign i2c_addr  = I2C_ADDR;
  assign i2c_data  = r_data;

endmodule

// File: tb/tb_lcd_i2c_seq.sv
// tb_lcd_i2c_seq: directed bench for lcd_i2c_seq with a scoreboard of expected
// expander bytes, checked by a simple I2C master model on every i2c_start.
module tb_lcd_i2c_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_byte = 8'h00;
  logic       req_ready, init_done, err, i2c_start;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       m_busy = 1'b0;
  logic       f_busy = 1'b0;
  logic       i2c_busy;
  logic       i2c_done = 1'b0;
  logic       i2c_nack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int nack_at = -1;
  int last_done_cyc = 0;
  logic [7:0] sbq [$];

  assign i2c_busy = m_busy | f_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_i2c_seq #(
    .CLK_HZ(1_000_000), .I2C_ADDR(7'h27), .POWERUP_MS(1), .BACKLIGHT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
    .req_byte(req_byte), .req_ready(req_ready), .init_done(init_done), .err(err),
    .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expander byte {D7..D4, BL=1, EN, RW=0, RS}
  function automatic logic [7:0] eb(input logic [3:0] nib, input logic en, input logic rs);
    return {nib, 1'b1, en, 1'b0, rs};
  endfunction

  function automatic int ref_dly(input logic rs, input logic [7:0] b);
    return (!rs && (b == 8'h01 || b == 8'h02)) ? 2000 : 50;
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0: return req_ready;
      1: return init_done;
      2: return err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] b);
    sbq.push_back(eb(b[7:4], 1'b1, rs));
    sbq.push_back(eb(b[7:4], 1'b0, rs));
    sbq.push_back(eb(b[3:0], 1'b1, rs));
    sbq.push_back(eb(b[3:0], 1'b0, rs));
  endtask

  task automatic push_init();
    logic [7:0] seq [24] = '{
      8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
      8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
      8'h0C, 8'h08, 8'h1C, 8'h18, 8'h0C, 8'h08, 8'h6C, 8'h68};
    foreach (seq[i]) sbq.push_back(seq[i]);
  endtask

  task automatic wait_for(input int which, input int maxc, input string tag, output int n);
    n = 0;
    while (!sig(which) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, sig(which)}, 32'd1);
  endtask

  // Releases reset, checks the power-up silence and the full init sequence.
  task automatic init_seq(input string tag);
    int s0, n;
    s0 = n_starts;
    rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    chk({tag, "_powerup_quiet"}, n_starts - s0, 0);
    chk({tag, "_not_done_early"}, {31'd0, init_done}, 0);
    wait_for(1, 20000, {tag, "_init_done"}, n);
    chk({tag, "_ready"}, {31'd0, req_ready}, 1);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_n_writes"}, n_starts - s0, 24);
    chk({tag, "_final_gap"}, {31'd0, (cyc - last_done_cyc) >= 50}, 1);
  endtask

  // Expected bytes must already be on the scoreboard; req_ready must be high.
  task automatic send_req(input logic rs, input logic [7:0] b, input string tag);
    int n, dly;
    dly = ref_dly(rs, b);
    req_valid = 1'b1; req_rs = rs; req_byte = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_start_lat"}, {31'd0, i2c_start}, 1);
    chk({tag, "_ready_low"}, {31'd0, req_ready}, 0);
    wait_for(0, dly + 200, tag, n);
    chk({tag, "_gap_min"}, {31'd0, n >= dly + 44}, 1);
    chk({tag, "_gap_max"}, {31'd0, n <= dly + 70}, 1);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  // I2C master model: 10-cycle transaction, then a one-cycle done pulse.
  always begin : master
    logic [7:0] exp;
    bit abort;
    @(posedge clk); #1;
    if (rst_n && i2c_start) begin
      n_starts++;
      chk("sb_start_expected", {31'd0, sbq.size() != 0}, 1);
      if (sbq.size() != 0) begin
        exp = sbq.pop_front();
        chk("sb_i2c_data", {24'd0, i2c_data}, {24'd0, exp});
      end
      m_busy = 1'b1;
      abort = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (!rst_n) abort = 1'b1;
      end
      m_busy = 1'b0;
      if (!abort) begin
        i2c_done = 1'b1;
        i2c_nack = ((n_starts - 1) == nack_at);
        last_done_cyc = cyc;
        @(posedge clk); #1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  initial begin
    int s0, n;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_init_done", {31'd0, init_done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_i2c_start", {31'd0, i2c_start}, 0);
    chk("rst_i2c_data", {24'd0, i2c_data}, 0);
    chk("i2c_addr", {25'd0, i2c_addr}, 32'h27);

    // 1: power-up and init
    push_init();
    init_seq("init1");

    // 2: data byte 'H'
    sbq.push_back(8'h4D); sbq.push_back(8'h49); sbq.push_back(8'h8D); sbq.push_back(8'h89);
    send_req(1'b1, 8'h48, "data48");

    // 3: clear command, long delay
    sbq.push_back(8'h0C); sbq.push_back(8'h08); sbq.push_back(8'h1C); sbq.push_back(8'h18);
    send_req(1'b0, 8'h01, "clear");

    // 5: master busy holds off the first write
    f_busy = 1'b1;
    push_byte(1'b1, 8'h3A);
    req_valid = 1'b1; req_rs = 1'b1; req_byte = 8'h3A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_accept_ready_low", {31'd0, req_ready}, 0);
    chk("busy_no_start_now", {31'd0, i2c_start}, 0);
    s0 = n_starts;
    repeat (20) @(posedge clk);
    #1;
    chk("busy_hold_no_start", n_starts - s0, 0);
    f_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_release_one_start", n_starts - s0, 1);
    wait_for(0, 400, "busy_ready", n);
    chk("busy_sb_empty", sbq.size(), 0);

    // 4: NACK on the second write of a request
    nack_at = n_starts + 1;
    sbq.push_back(eb(4'h4, 1'b1, 1'b1)); sbq.push_back(eb(4'h4, 1'b0, 1'b1));
    req_valid = 1'b1; req_rs = 1'b1; req_byte = 8'h41;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_for(2, 100, "nack_err", n);
    chk("nack_ready_low", {31'd0, req_ready}, 0);
    s0 = n_starts;
    repeat (200) @(posedge clk);
    #1;
    chk("nack_no_more_start", n_starts - s0, 0);
    chk("nack_err_sticky", {31'd0, err}, 1);
    chk("nack_ready_stays_low", {31'd0, req_ready}, 0);
    chk("nack_sb_empty", sbq.size(), 0);
    nack_at = -1;

    // Reset clears the error and replays init
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_err", {31'd0, err}, 0);
    sbq.delete();
    push_init();
    init_seq("init2");

    // 6: async reset during WAIT_DONE of a data byte
    push_byte(1'b1, 8'h55);
    req_valid = 1'b1; req_rs = 1'b1; req_byte = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_data", {24'd0, i2c_data}, 32'h5D);
    chk("pre_rst_init_done", {31'd0, init_done}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 0);
    chk("arst_init_done", {31'd0, init_done}, 0);
    chk("arst_err", {31'd0, err}, 0);
    chk("arst_i2c_start", {31'd0, i2c_start}, 0);
    chk("arst_i2c_data", {24'd0, i2c_data}, 0);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    push_init();
    init_seq("init3");

    // Return-home command also takes the long delay
    push_byte(1'b0, 8'h02);
    send_req(1'b0, 8'h02, "home");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
